// File: rtl/palette_arbiter.sv
`default_nettype none
// ============================================================================
// palette_arbiter : round-robin arbiter feeding a shared palette mapper
//                   through a two-stage pipeline with response backpressure
// Revision 1.0
// ============================================================================
module palette_arbiter #(
  parameter int         NUM_REQ         = 4,
  parameter logic [4:0] TRANSPARENT_IDX = 5'h1F,
  parameter logic [4:0] MAX_IDX         = 5'h16
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [5*NUM_REQ-1:0]       req_index,
  input  logic                       lookup_en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [4:0]                 pal_index,
  input  logic [23:0]                pal_rgb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [23:0]                rsp_rgb,
  output logic                       rsp_transparent,
  output logic                       rsp_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [4:0]      s1_idx;
  logic [ID_W-1:0] rr_ptr;

  logic            s2_load;
  logic            s1_load;
  logic            grant_en;
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;
  logic [4:0]      win_idx;
  logic            is_transparent;
  logic            is_err;
  logic [23:0]     next_rgb;

  assign s2_load   = !rsp_valid || rsp_ready;
  assign s1_load   = s2_load || !s1_valid;
  assign pal_index = s1_idx;

  // First requesting port at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + ID_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Reset gating keeps gnt low while the block is held in reset
  assign grant_en = lookup_en && s1_load && found && !Reset;
  assign win_idx  = req_index[5*int'(win) +: 5];

  always_comb begin
    gnt = '0;
    if (grant_en) begin
      gnt[win] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_idx   <= '0;
      rr_ptr   <= '0;
    end else if (s1_load) begin
      s1_valid <= grant_en;
      if (grant_en) begin
        s1_id  <= win;
        s1_idx <= win_idx;
        rr_ptr <= win + ID_W'(1);
      end
    end
  end

  assign is_transparent = (s1_idx == TRANSPARENT_IDX);
  assign is_err         = !is_transparent && (s1_idx > MAX_IDX);
  assign next_rgb       = (is_transparent || is_err) ? 24'h000000 : pal_rgb;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_rgb         <= '0;
      rsp_transparent <= 1'b0;
      rsp_err         <= 1'b0;
    end else if (s2_load) begin
      rsp_valid       <= s1_valid;
      rsp_id          <= s1_id;
      rsp_rgb         <= next_rgb;
      rsp_transparent <= is_transparent;
      rsp_err         <= is_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_palette_arbiter.sv
`default_nettype none
// ============================================================================
// tb_palette_arbiter : directed and randomized checks against a slot model
// Revision 1.0
// ============================================================================
module tb_palette_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  req = '0;
  logic [19:0] req_index = '0;
  logic        lookup_en = 1'b1;
  logic [3:0]  gnt;
  logic [4:0]  pal_index;
  logic [23:0] pal_rgb;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_rgb;
  logic        rsp_transparent;
  logic        rsp_err;

  logic [23:0] pal [32];
  assign pal_rgb = pal[pal_index];

  palette_arbiter #(.NUM_REQ(4), .TRANSPARENT_IDX(5'h1F), .MAX_IDX(5'h16)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_index(req_index),
    .lookup_en(lookup_en), .gnt(gnt), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rgb(rsp_rgb), .rsp_transparent(rsp_transparent), .rsp_err(rsp_err)
  );

  always #5 Clk = ~Clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input logic [4:0] ix);
    if (ix == 5'h1F || ix > 5'h16) return 24'h000000;
    return pal[ix];
  endfunction

  // Model: an optional lookup slot and an optional response slot
  int         m_ptr;
  bit         m1v, m2v;
  int         m1id, m2id;
  logic [4:0] m1idx, m2idx;
  logic [3:0] last_gnt = '0;
  int         n_gnt = 0;
  int         n_rsp = 0;

  always @(negedge Clk) begin
    int w;
    bit out_ok, s1_free;
    logic [3:0] eg;
    last_gnt = gnt;
    if (Reset) begin
      chk("reset_gnt", gnt, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_rsp_rgb", rsp_rgb, 0);
      chk("reset_rsp_flags", {rsp_transparent, rsp_err}, 0);
      chk("reset_pal_index", pal_index, 0);
      m_ptr = 0; m1v = 0; m2v = 0;
      n_gnt = 0; n_rsp = 0;
    end else begin
      out_ok  = !m2v || rsp_ready;
      s1_free = out_ok || !m1v;
      eg = '0;
      w  = -1;
      if (lookup_en && s1_free)
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) eg[w] = 1'b1;
      chk("gnt", gnt, eg);
      if (m1v) chk("pal_index", pal_index, m1idx);
      chk("rsp_valid", rsp_valid, m2v);
      if (m2v) begin
        chk("rsp_id", rsp_id, m2id);
        chk("rsp_rgb", rsp_rgb, ref_rgb(m2idx));
        chk("rsp_transparent", rsp_transparent, m2idx == 5'h1F);
        chk("rsp_err", rsp_err, (m2idx > 5'h16) && (m2idx != 5'h1F));
      end
      n_gnt += $countones(gnt);
      if (rsp_valid && rsp_ready) n_rsp++;
      if (out_ok) begin
        m2v = m1v; m2id = m1id; m2idx = m1idx;
      end
      if (s1_free) begin
        m1v = (w >= 0);
        if (w >= 0) begin
          m1id  = w;
          m1idx = req_index[5*w +: 5];
          m_ptr = (w + 1) % 4;
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic single(input int i, input logic [4:0] ix, input logic [23:0] rgb,
                        input logic t, input logic e);
    step();
    req = 4'(1 << i);
    req_index[5*i +: 5] = ix;
    @(negedge Clk);
    chk("single_gnt", gnt, 1 << i);
    step();
    req = '0;
    @(negedge Clk);
    chk("single_pal_index", pal_index, ix);
    @(negedge Clk);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, i);
    chk("single_rsp_rgb", rsp_rgb, rgb);
    chk("single_rsp_transparent", rsp_transparent, t);
    chk("single_rsp_err", rsp_err, e);
  endtask

  bit         pending [4];
  logic [4:0] pidx [4];
  int         cnt;

  initial begin
    for (int i = 0; i < 32; i++) pal[i] = 24'($urandom);
    pal[5] = 24'h0058F8;

    // Round-robin with all four requesting from reset release
    req = 4'hF;
    req_index = {5'h03, 5'h02, 5'h01, 5'h00};
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("rr_order", gnt, 1 << (k % 4));
    end
    step();
    req = '0;
    repeat (3) @(negedge Clk);

    single(0, 5'h05, 24'h0058F8, 1'b0, 1'b0);
    single(1, 5'h1F, 24'h000000, 1'b1, 1'b0);
    single(2, 5'h17, 24'h000000, 1'b0, 1'b1);
    single(3, 5'h16, pal[5'h16], 1'b0, 1'b0);

    // lookup_en low blocks grants, raising it releases the waiting request
    step();
    lookup_en = 1'b0;
    req = 4'b0100;
    req_index[14:10] = 5'h09;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("en_low_gnt", gnt, 0);
      step();
    end
    lookup_en = 1'b1;
    @(negedge Clk);
    chk("en_high_gnt", gnt, 4'b0100);
    step();
    req = '0;
    repeat (3) @(negedge Clk);

    // Backpressure from an empty pipeline: only two slots can fill
    step();
    rsp_ready = 1'b0;
    req = 4'b0011;
    req_index[9:0] = {5'h02, 5'h01};
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      cnt += $countones(gnt);
      step();
    end
    chk("bp_grant_count", cnt, 2);
    rsp_ready = 1'b1;
    req = '0;
    repeat (4) @(negedge Clk);

    // Reset with both stages full
    step();
    rsp_ready = 1'b0;
    req = 4'b0011;
    @(negedge Clk);
    step();
    @(negedge Clk);
    step();
    Reset = 1'b1;
    req = '0;
    @(negedge Clk);
    chk("midreset_rsp_valid", rsp_valid, 0);
    step();
    Reset = 1'b0;
    rsp_ready = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge Clk);
      cnt += int'(rsp_valid);
    end
    chk("no_stale_rsp", cnt, 0);

    // Randomized traffic with withdrawals, enable gaps, stalls and resets
    for (int i = 0; i < 4; i++) pending[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 249) == 0) Reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (pending[i] && last_gnt[i]) pending[i] = 1'b0;
        else if (pending[i] && $urandom_range(0, 19) == 0) pending[i] = 1'b0;
        else if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          case ($urandom_range(0, 4))
            0: pidx[i] = 5'h1F;
            1: pidx[i] = 5'h17;
            2: pidx[i] = 5'h16;
            default: pidx[i] = 5'($urandom);
          endcase
        end
        req[i] = pending[i];
        req_index[5*i +: 5] = pidx[i];
      end
      lookup_en = ($urandom_range(0, 7) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    Reset = 1'b0;
    req = '0;
    rsp_ready = 1'b1;
    lookup_en = 1'b1;
    repeat (4) @(negedge Clk);
    #1;
    chk("grants_vs_responses", n_rsp, n_gnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
